bp_mem_latency_stub: RTL and testbench
======================================

Name: bp_mem_latency_stub

Overview:
- Fixed-latency memory endpoint for the single-core BlackParrot test harness.
- Consumes the chip's mem_cmd stream and produces its mem_resp stream. Connects directly to the chip-level mem_cmd_o/v_o/ready_i and mem_resp_i/v_i/yumi_o ports.
- Holds a block-granular backing store and returns in-order responses a programmable number of cycles after each command is accepted.

Parameters:
- paddr_width_p, 40, physical address width
- block_width_p, 512, data field width (one cache block, 64 B)
- mem_els_p, 256, backing-store blocks; must be a power of two
- latency_p, 4, cycles from command acceptance to response valid; range 1..15
- els_p, 4, maximum outstanding commands
- msg_width_lp, derived, block_width_p+paddr_width_p+7, message width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- mem_cmd_i  in  msg_width_lp  command message
- mem_cmd_v_i  in  1  command valid
- mem_cmd_ready_o  out  1  command ready (ready/valid handshake)
- mem_resp_o  out  msg_width_lp  response message
- mem_resp_v_o  out  1  response valid
- mem_resp_yumi_i  in  1  response consumed (yumi; asserted only while v_o=1)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Message layout, LSB first:
  - [3:0] msg_type: 0=rd, 1=wr, 2=uc_rd, 3=uc_wr; all other values are treated as rd.
  - [paddr_width_p+3:4] addr.
  - [paddr_width_p+6:paddr_width_p+4] size, log2 bytes, 0..6.
  - Upper block_width_p bits are data.
- Block index: addr[6 +: log2(mem_els_p)]. Higher address bits are ignored, so the store wraps.
- Accept rule: command accepted when mem_cmd_v_i & mem_cmd_ready_o.
  - mem_cmd_ready_o = state READY & queue not full.
  - Does not depend on mem_resp_yumi_i, so there is no same-cycle enqueue when full.
- Memory access happens in the accept cycle, so later commands observe earlier writes.
  - rd: returns the full block.
  - uc_rd: returns the 2^size bytes at addr[5:0], aligned down to size. Result is right-justified with upper bits zero.
  - wr: overwrites the full block.
  - uc_wr: writes 2^size bytes from data[8*2^size-1:0] at the aligned offset addr[5:0]. Other bytes are unchanged.
  - size>6 is treated as 6.
- Response: header identical to the command (type, addr, size). Data = read result for reads, all zero for writes.
- Response queue:
  - In-order FIFO of els_p entries. Each entry holds the response message plus a 4-bit countdown loaded with latency_p-1 at accept.
  - All non-zero countdowns decrement every cycle.
  - mem_resp_v_o = head valid & head countdown==0.
  - The countdown is not extended while the head is stalled. A waiting entry behind a stalled head becomes visible the cycle after the head is yumi'd.
  - Unloaded path: command accepted in cycle t gives mem_resp_v_o=1 in cycle t+latency_p.
- Simultaneous accept and yumi: both take effect; occupancy is unchanged.
- Pointers wrap modulo els_p; full/empty are distinguished by an occupancy counter.
- State machine:
  - INIT → READY when the init sweep finishes; with the feature compiled out, READY directly.
  - READY has no exit except reset.
- Reset mid-operation: queue is flushed; no response from pre-reset commands ever appears.
  - Backing-store contents are retained unless the optional feature is compiled in.
- Reset values: mem_cmd_ready_o=0 during reset; mem_resp_v_o=0; mem_resp_o=0 while the queue is empty.

Optional Feature:
- Macro: BP_MEM_LATENCY_STUB_ZERO_INIT_EN.
- Defined:
  - After reset deasserts, the state machine stays in INIT for mem_els_p cycles, writing zero to one block per cycle with an incrementing index.
  - mem_cmd_ready_o=0 throughout INIT; then READY.
  - Any read before an explicit write returns zero.
- Undefined:
  - READY in the first cycle after reset.
  - Store is uninitialised; reads of unwritten blocks return X in simulation.

Test Plan:
- Single read, unloaded, latency_p=4, ZERO_INIT_EN defined: rd addr 0x80000040 accepted at t → mem_resp_v_o=1 at t+4, data=0, header equals command.
- Write then read: wr addr 0x80000000 data=0xA5 repeated ×64 at t, rd same addr at t+1 → two responses at t+4 and t+5 (write data 0, read data 0xA5 repeated ×64).
- Uncached partial write/read: uc_wr addr 0x80000008 size=3 data=0x1122334455667788, then uc_rd same addr size=2 → read data=0x55667788 in bits [31:0], upper bits zero; other bytes of the block unchanged.
- Backpressure and full:
  - Issue 6 back-to-back rds with mem_resp_yumi_i held 0 → ready_o drops after 4 accepts.
  - Release yumi → 6 responses in order, one per cycle once visible.
  - ready_o reasserts the cycle after the first yumi.
- Aliasing: wr addr 0x80000000, then rd addr 0x80004000 (mem_els_p=256) → read returns the written block.
- Reset mid-flight: 2 rds accepted, reset asserted 1 cycle later for 1 cycle → mem_resp_v_o stays 0 and no response from the flushed commands ever appears.
  - With ZERO_INIT_EN defined: ready_o=0 for 256 cycles, then 1.

Source files
------------

// File: rtl/bp_mem_latency_stub.sv
`default_nettype none
// ============================================================================
// Module   : bp_mem_latency_stub
// Purpose  : Fixed-latency memory endpoint for the single-core BlackParrot
//            test harness. Accepts mem_cmd messages, performs the block or
//            uncached sub-block access against a block-granular backing store
//            in the accept cycle, and returns in-order mem_resp messages
//            latency_p cycles after acceptance.
//
// Ports    : clk_i            in   clock
//            reset_i          in   synchronous, active-high reset
//            mem_cmd_i        in   command message {data, size, addr, type}
//            mem_cmd_v_i      in   command valid
//            mem_cmd_ready_o  out  command ready (ready/valid handshake)
//            mem_resp_o       out  response message (zero while queue empty)
//            mem_resp_v_o     out  response valid
//            mem_resp_yumi_i  in   response consumed (only while v_o=1)
//
// Options  : BP_MEM_LATENCY_STUB_ZERO_INIT_EN - when defined, the store is
//            swept to zero (one block per cycle) after every reset before
//            commands are accepted.
//
// Revision : 1.0 - initial release
// ============================================================================
module bp_mem_latency_stub #(
    parameter int  paddr_width_p = 40,
    parameter int  block_width_p = 512,
    parameter int  mem_els_p     = 256,
    parameter int  latency_p     = 4,
    parameter int  els_p         = 4,
    localparam int msg_width_lp  = block_width_p + paddr_width_p + 7
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [msg_width_lp-1:0] mem_cmd_i,
    input  logic                    mem_cmd_v_i,
    output logic                    mem_cmd_ready_o,
    output logic [msg_width_lp-1:0] mem_resp_o,
    output logic                    mem_resp_v_o,
    input  logic                    mem_resp_yumi_i
);

    localparam int c_idx_w = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int c_ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int c_cnt_w = $clog2(els_p + 1);
    localparam int c_hdr_w = paddr_width_p + 7;
    localparam int c_bytes = block_width_p / 8;

    localparam logic [3:0] c_lat_load = 4'(latency_p - 1);

    localparam logic [3:0] c_MSG_WR    = 4'd1;
    localparam logic [3:0] c_MSG_UC_RD = 4'd2;
    localparam logic [3:0] c_MSG_UC_WR = 4'd3;

    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;
`ifdef BP_MEM_LATENCY_STUB_ZERO_INIT_EN
    localparam logic [0:0] c_ST_RESET = c_ST_INIT;
`else
    localparam logic [0:0] c_ST_RESET = c_ST_READY;
`endif

    // ------------------------------------------------------------------
    // Command field extraction
    // ------------------------------------------------------------------
    logic [3:0]               w_cmd_type;
    logic [2:0]               w_cmd_size;
    logic [2:0]               w_size_eff;
    logic [5:0]               w_cmd_off;
    logic [block_width_p-1:0] w_cmd_data;
    logic [c_idx_w-1:0]       w_idx;

    assign w_cmd_type = mem_cmd_i[3:0];
    assign w_cmd_off  = mem_cmd_i[9:4];
    assign w_idx      = mem_cmd_i[10 +: c_idx_w];
    assign w_cmd_size = mem_cmd_i[paddr_width_p+6 -: 3];
    assign w_cmd_data = mem_cmd_i[msg_width_lp-1 -: block_width_p];
    assign w_size_eff = (w_cmd_size > 3'd6) ? 3'd6 : w_cmd_size;

    // ------------------------------------------------------------------
    // State, queue bookkeeping
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_empty;
    logic               w_full;
    logic               w_cmd_ready;
    logic               w_accept;
    logic               w_resp_v;
    logic               w_pop;

    logic [msg_width_lp-1:0] r_q_msg [els_p];
    logic [3:0]              r_q_cnt [els_p];

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_cnt_w'(els_p));
    // Ready is forced low during reset because the state register may already
    // hold READY from before the reset was raised.
    assign w_cmd_ready = ~reset_i & (r_state == c_ST_READY) & ~w_full;
    assign w_accept    = mem_cmd_v_i & w_cmd_ready;
    assign w_resp_v    = ~reset_i & ~w_empty & (r_q_cnt[r_rd_ptr] == 4'd0);
    assign w_pop       = w_resp_v & mem_resp_yumi_i;

    assign mem_cmd_ready_o = w_cmd_ready;
    assign mem_resp_v_o    = w_resp_v;
    assign mem_resp_o      = w_empty ? '0 : r_q_msg[r_rd_ptr];

    // ------------------------------------------------------------------
    // Backing store and access datapath
    // ------------------------------------------------------------------
    logic [block_width_p-1:0] r_mem [mem_els_p];
    logic [block_width_p-1:0] w_rd_block;
    logic [block_width_p-1:0] w_lo_mask;
    logic [block_width_p-1:0] w_hit_mask;
    logic [block_width_p-1:0] w_uc_rd_data;
    logic [block_width_p-1:0] w_uc_wr_block;
    logic [block_width_p-1:0] w_wr_block;
    logic [block_width_p-1:0] w_resp_data;
    logic [msg_width_lp-1:0]  w_resp_msg;
    logic [5:0]               w_off;
    logic [6:0]               w_nbytes;
    logic [8:0]               w_shamt;
    logic                     w_mem_we;

    assign w_rd_block = r_mem[w_idx];
    assign w_nbytes   = 7'd1 << w_size_eff;
    // Align the byte offset down to the access size; for size 6 the mask
    // term wraps to all-zero, giving offset 0.
    assign w_off      = w_cmd_off & ~((6'd1 << w_size_eff) - 6'd1);
    assign w_shamt    = {w_off, 3'b000};

    always_comb begin
        w_lo_mask = '0;
        for (int b = 0; b < c_bytes; b++) begin
            w_lo_mask[8*b +: 8] = (b < int'(w_nbytes)) ? 8'hFF : 8'h00;
        end
    end

    assign w_hit_mask    = w_lo_mask << w_shamt;
    assign w_uc_rd_data  = (w_rd_block >> w_shamt) & w_lo_mask;
    assign w_uc_wr_block = (w_rd_block & ~w_hit_mask) | ((w_cmd_data << w_shamt) & w_hit_mask);

    always_comb begin
        w_mem_we    = 1'b0;
        w_wr_block  = w_cmd_data;
        w_resp_data = w_rd_block;
        case (w_cmd_type)
            c_MSG_WR: begin
                w_mem_we    = w_accept;
                w_wr_block  = w_cmd_data;
                w_resp_data = '0;
            end
            c_MSG_UC_RD: begin
                w_resp_data = w_uc_rd_data;
            end
            c_MSG_UC_WR: begin
                w_mem_we    = w_accept;
                w_wr_block  = w_uc_wr_block;
                w_resp_data = '0;
            end
            default: begin
                w_resp_data = w_rd_block;
            end
        endcase
    end

    assign w_resp_msg = {w_resp_data, mem_cmd_i[c_hdr_w-1:0]};

`ifdef BP_MEM_LATENCY_STUB_ZERO_INIT_EN
    logic [c_idx_w-1:0] r_init_idx;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_init_idx <= '0;
        end else if (r_state == c_ST_INIT) begin
            r_init_idx <= r_init_idx + c_idx_w'(1);
        end
    end
`endif

    // Store has no reset; contents survive reset unless the sweep is built in.
    always_ff @(posedge clk_i) begin
`ifdef BP_MEM_LATENCY_STUB_ZERO_INIT_EN
        if (!reset_i && (r_state == c_ST_INIT)) begin
            r_mem[r_init_idx] <= '0;
        end else
`endif
        if (w_mem_we) begin
            r_mem[w_idx] <= w_wr_block;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT: begin
`ifdef BP_MEM_LATENCY_STUB_ZERO_INIT_EN
                if (r_init_idx == c_idx_w'(mem_els_p - 1)) begin
                    w_state_nxt = c_ST_READY;
                end
`else
                w_state_nxt = c_ST_READY;
`endif
            end
            default: begin
                w_state_nxt = c_ST_READY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response queue
    // ------------------------------------------------------------------
    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(els_p - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Every entry counts down independently, so a stalled head does not delay
    // the entries queued behind it.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < els_p; i++) begin
            if (w_accept && (r_wr_ptr == c_ptr_w'(i))) begin
                r_q_msg[i] <= w_resp_msg;
                r_q_cnt[i] <= c_lat_load;
            end else if (r_q_cnt[i] != 4'd0) begin
                r_q_cnt[i] <= r_q_cnt[i] - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_mem_latency_stub.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_mem_latency_stub
// Purpose  : Self-checking bench for bp_mem_latency_stub. A byte-addressed
//            reference memory and a queue of expected responses (each with
//            the cycle from which it may be presented) predict ready, valid
//            and response contents every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_mem_latency_stub;

    localparam int PADDR  = 40;
    localparam int BW     = 512;
    localparam int MEMELS = 256;
    localparam int LAT    = 4;
    localparam int QELS   = 4;
    localparam int MW     = BW + PADDR + 7;
    localparam int HW     = PADDR + 7;

    localparam logic [3:0] T_RD   = 4'd0;
    localparam logic [3:0] T_WR   = 4'd1;
    localparam logic [3:0] T_UCRD = 4'd2;
    localparam logic [3:0] T_UCWR = 4'd3;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [MW-1:0] mem_cmd_i;
    logic          mem_cmd_v_i;
    logic          mem_cmd_ready_o;
    logic [MW-1:0] mem_resp_o;
    logic          mem_resp_v_o;
    logic          mem_resp_yumi_i;

    always #5 clk_i = ~clk_i;

    bp_mem_latency_stub #(
        .paddr_width_p (PADDR),
        .block_width_p (BW),
        .mem_els_p     (MEMELS),
        .latency_p     (LAT),
        .els_p         (QELS)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .mem_cmd_i       (mem_cmd_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_ready_o (mem_cmd_ready_o),
        .mem_resp_o      (mem_resp_o),
        .mem_resp_v_o    (mem_resp_v_o),
        .mem_resp_yumi_i (mem_resp_yumi_i)
    );

    typedef struct {
        logic [MW-1:0] msg;
        longint        due;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mm [MEMELS*64];
    int         n_pass = 0;
    int         n_fail = 0;
    int         n_total = 0;
    longint     cyc = 0;
    int         init_left = 0;

    function automatic logic [MW-1:0] mk(input logic [3:0] t, input logic [PADDR-1:0] a,
                                         input logic [2:0] s, input logic [BW-1:0] d);
        return {d, s, a, t};
    endfunction

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] r;
        for (int i = 0; i < BW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one accepted command.
    task automatic model_accept(input logic [MW-1:0] c);
        logic [3:0]       t;
        logic [PADDR-1:0] a;
        logic [BW-1:0]    d;
        logic [BW-1:0]    r;
        int               sz, n, off, base;
        t    = c[3:0];
        a    = c[PADDR+3:4];
        sz   = int'(c[PADDR+6:PADDR+4]);
        d    = c[MW-1:HW];
        r    = '0;
        base = int'((a >> 6) % MEMELS) * 64;
        if (sz > 6) sz = 6;
        n    = 1 << sz;
        off  = (int'(a[5:0]) / n) * n;
        case (t)
            T_WR:    for (int b = 0; b < 64; b++) mm[base+b] = d[8*b +: 8];
            T_UCRD:  for (int b = 0; b < n; b++) r[8*b +: 8] = mm[base+off+b];
            T_UCWR:  for (int b = 0; b < n; b++) mm[base+off+b] = d[8*b +: 8];
            default: for (int b = 0; b < 64; b++) r[8*b +: 8] = mm[base+b];
        endcase
        q.push_back('{msg: {r, c[HW-1:0]}, due: cyc + LAT});
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic tick(input logic v, input logic [MW-1:0] c, input logic yreq, output logic acc);
        logic ev, er;
        mem_cmd_v_i = v;
        mem_cmd_i   = c;
        ev = (q.size() > 0) && (cyc >= q[0].due);
        er = (init_left == 0) && (q.size() < QELS);
        mem_resp_yumi_i = yreq & ev;
        @(negedge clk_i);
        chk("cmd_ready", mem_cmd_ready_o, er);
        chk("resp_v", mem_resp_v_o, ev);
        if (ev) chk("resp_msg", mem_resp_o, q[0].msg);
        else if (q.size() == 0) chk("resp_idle_zero", mem_resp_o, '0);
        acc = v & er;
        if (mem_resp_yumi_i) void'(q.pop_front());
        if (acc) model_accept(c);
        if (init_left > 0) init_left--;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic yreq);
        logic acc;
        repeat (n) tick(1'b0, '0, yreq, acc);
    endtask

    task automatic send(input logic [MW-1:0] c, input logic yreq);
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 50) begin
            tick(1'b1, c, yreq, acc);
            k++;
        end
        if (!acc) begin
            n_total++;
            n_fail++;
            $display("FAIL send_timeout: command not accepted within 50 cycles");
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < 200) begin
            idle(1, 1'b1);
            k++;
        end
        if (q.size() > 0) begin
            n_total++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding", q.size());
        end
    endtask

    task automatic wait_init();
        while (init_left > 0) idle(1, 1'b1);
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            reset_i         = 1'b1;
            mem_cmd_v_i     = 1'b0;
            mem_resp_yumi_i = 1'b0;
            @(negedge clk_i);
            chk("rst_ready", mem_cmd_ready_o, 1'b0);
            chk("rst_resp_v", mem_resp_v_o, 1'b0);
            @(posedge clk_i);
            #1;
            cyc++;
        end
        reset_i = 1'b0;
        q.delete();
`ifdef BP_MEM_LATENCY_STUB_ZERO_INIT_EN
        init_left = MEMELS;
        foreach (mm[i]) mm[i] = 8'h00;
`endif
    endtask

    initial begin
        logic             acc;
        logic             v;
        logic [3:0]       t;
        logic [PADDR-1:0] a;
        logic [BW-1:0]    blk;
        int               k;

        reset_i         = 1'b1;
        mem_cmd_v_i     = 1'b0;
        mem_cmd_i       = '0;
        mem_resp_yumi_i = 1'b0;
        @(posedge clk_i);
        #1;
        do_reset(2);
        wait_init();

`ifdef BP_MEM_LATENCY_STUB_ZERO_INIT_EN
        // Unwritten block reads back as zero after the sweep.
        send(mk(T_RD, 40'h80000040, 3'd6, '0), 1'b1);
        drain();
`endif

        // Give blocks 0..7 known contents.
        for (int i = 0; i < 8; i++) send(mk(T_WR, 40'h80000000 + 40'(i*64), 3'd6, rand_blk()), 1'b1);
        drain();

        // Write then read back-to-back.
        blk = {64{8'hA5}};
        send(mk(T_WR, 40'h80000000, 3'd6, blk), 1'b1);
        send(mk(T_RD, 40'h80000000, 3'd6, '0), 1'b1);
        drain();

        // Uncached partial write and read, then full-block read.
        send(mk(T_UCWR, 40'h80000008, 3'd3, BW'(64'h1122334455667788)), 1'b1);
        send(mk(T_UCRD, 40'h80000008, 3'd2, '0), 1'b1);
        send(mk(T_RD, 40'h80000000, 3'd6, '0), 1'b1);
        drain();

        // Backpressure: six reads with yumi held low, then released.
        k = 0;
        repeat (8) begin
            tick(1'b1, mk(T_RD, 40'h80000000 + 40'(k*64), 3'd6, '0), 1'b0, acc);
            if (acc) k++;
        end
        while (k < 6) begin
            send(mk(T_RD, 40'h80000000 + 40'(k*64), 3'd6, '0), 1'b1);
            k++;
        end
        drain();

        // Address aliasing past the end of the store.
        send(mk(T_WR, 40'h80000000, 3'd6, rand_blk()), 1'b1);
        send(mk(T_RD, 40'h80004000, 3'd6, '0), 1'b1);
        drain();

        // Random traffic over blocks 0..7 with random upper address bits.
        repeat (300) begin
            v = ($urandom_range(0, 2) != 0);
            t = 4'($urandom_range(0, 5));
            if (t >= 4'd4) t = 4'($urandom_range(4, 15));
            a = {$urandom, $urandom};
            a[13:6] = {5'b0, 3'($urandom)};
            tick(v, mk(t, a, 3'($urandom), rand_blk()), ($urandom_range(0, 3) != 0), acc);
        end
        drain();

        // Reset with two reads in flight: nothing from them may appear.
        send(mk(T_RD, 40'h80000000, 3'd6, '0), 1'b0);
        send(mk(T_RD, 40'h80000040, 3'd6, '0), 1'b0);
        idle(1, 1'b0);
        do_reset(1);
        wait_init();
        idle(12, 1'b1);

        // Store contents after reset still match the model.
        send(mk(T_RD, 40'h80000080, 3'd6, '0), 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
